sw_debouncer: RTL

Front-end conditioning stage for the board slide switches. It sits directly upstream of the switch-to-LED logic and drives its sw_i bus.
- Synchronises each raw switch line into the clock domain.
- Filters contact bounce with a per-bit stability counter.
- Presents a clean level bus plus one-cycle rise/fall event strobes for downstream logic.

---
 rtl/sw_debouncer_if.sv | 27 ++
 rtl/sw_debouncer.sv | 81 ++++++++
 2 files changed

// File: rtl/sw_debouncer_if.sv
// Switch bus between raw switch source and debounced consumers.
// Carries raw levels in, clean levels and edge strobes out.
interface sw_debouncer_if #(
  parameter int WIDTH = 7
);
  logic [WIDTH-1:0] sw_i;
  logic [WIDTH-1:0] sw_o;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;
  logic             changed_o;

  modport master (
    output sw_i,
    input  sw_o,
    input  rise_o,
    input  fall_o,
    input  changed_o
  );

  modport slave (
    input  sw_i,
    output sw_o,
    output rise_o,
    output fall_o,
    output changed_o
  );
endinterface

// File: rtl/sw_debouncer.sv
// Slide-switch conditioner: per-bit synchroniser, stability
// filter, registered level bus and one-cycle rise/fall strobes.
module sw_debouncer #(
  parameter int WIDTH         = 7,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 100000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  sw_debouncer_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] sw_q;
  logic [WIDTH-1:0] sw_d;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic             changed_q;
  logic             changed_d;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        sync_q[s] <= '0;
      for (int b = 0; b < WIDTH; b++)
        cnt_q[b] <= '0;
      sw_q      <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      sync_q[0] <= bus.sw_i;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_q[s-1];
      for (int b = 0; b < WIDTH; b++)
        cnt_q[b] <= cnt_d[b];
      sw_q      <= sw_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  // Any return to the accepted level wipes the count.
  always_comb begin
    sw_d = sw_q;
    acc  = '0;
    for (int b = 0; b < WIDTH; b++) begin
      cnt_d[b] = '0;
      if (sync[b] != sw_q[b]) begin
        if (cnt_q[b] == LAST) begin
          acc[b]  = 1'b1;
          sw_d[b] = sync[b];
        end else begin
          cnt_d[b] = cnt_q[b] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    rise_d    = acc & sync;
    fall_d    = acc & ~sync;
    changed_d = |acc;
  end

  assign bus.sw_o      = sw_q;
  assign bus.rise_o    = rise_q;
  assign bus.fall_o    = fall_q;
  assign bus.changed_o = changed_q;
endmodule
